led_ring_monitor: RTL
=====================

// Module: led_ring_monitor
// PURPOSE
//  Observer for the rotating one-hot LED shifter: samples the LED vector and the advance strobe that drive it.
//  Checks every transition against the shifter protocol, tracks LED position and counts full revolutions.
//  Flags protocol violations with a sticky error. Sits beside the shifter in the LED demo top; feeds debug/VIO.
// PARAMETERS
//  NB_LEDS  4  width of monitored LED vector; legal >=2
//  NB_POS   2  width of o_pos; must satisfy 2**NB_POS >= NB_LEDS
//  NB_REV   8  width of revolution counter
// PORTS
//  clock        in   1        clock, rising edge
//  i_reset      in   1        reset, synchronous, active-high
//  i_led        in   NB_LEDS  LED vector under observation (shifter output)
//  i_valid      in   1        advance strobe, same net that drives the shifter
//  i_clear      in   1        return to UNLOCK, clear error and counters
//  o_pos        out  NB_POS   index of the lit LED
//  o_rev_count  out  NB_REV   completed revolutions, wraps modulo 2**NB_REV
//  o_locked     out  1        monitor is tracking a valid pattern
//  o_error      out  1        sticky protocol error
//  o_err_code   out  2        01 not one-hot, 10 unexpected change, 11 missed step
//  o_dir        out  1        last step direction, 1 = left (toward MSB)
// BEHAVIOUR
//  Reset values: o_pos 0, o_rev_count 0, o_locked 0, o_error 0, o_err_code 00, o_dir 1; state UNLOCK.
//  i_reset dominates i_clear; i_clear dominates any error detected in the same cycle.
//  Registers each cycle: led_q <= i_led, valid_q <= i_valid. Shifter changes one cycle after valid.
//  All outputs registered; o_pos reflects i_led one cycle later.
//  FSM UNLOCK -> LOCKED -> ERROR:
//   UNLOCK: i_valid ignored; if i_led is one-hot -> LOCKED, o_pos <= index, o_locked <= 1; else stay.
//   LOCKED, check i_led against led_q:
//    i_led not one-hot                        -> ERROR, code 01
//    valid_q=1, i_led == rotl(led_q)          -> step: o_pos+1 mod NB_LEDS, o_dir <= 1
//    valid_q=1, i_led == led_q                -> ERROR, code 11
//    valid_q=0, i_led != led_q                -> ERROR, code 10
//    valid_q=1, any other value               -> ERROR, code 10
//    valid_q=0, i_led == led_q                -> hold
//   Step wrapping o_pos NB_LEDS-1 -> 0: o_rev_count+1, wraps to 0 at max.
//   ERROR: o_error=1, o_locked=0; o_pos, o_rev_count, o_err_code frozen; exit only via i_reset or i_clear.
//  i_clear in any state: next cycle UNLOCK, o_error 0, o_err_code 00, o_rev_count 0, o_pos 0.
//  NB_LEDS=2: rotl == rotr; always treated as left step.
// CONFIGURATION
//  LED_MON_BIDIR_EN defined:
//   LOCKED also accepts valid_q=1 with i_led == rotr(led_q): o_pos-1 mod NB_LEDS, o_dir <= 0.
//   Wrap 0 -> NB_LEDS-1 also increments o_rev_count.
//  LED_MON_BIDIR_EN undefined: rotr step is an error, code 10; o_dir constant 1.
// STRUCTURE
//  Package led_ring_pkg: FSM state encoding (UNLOCK, LOCKED, ERROR).
//   Also: error-code constants ERR_NONE/ERR_ONEHOT/ERR_UNEXP/ERR_MISS, rotl/rotr functions.
//  Sub-module onehot_encoder: combinational; i_vec -> o_onehot flag, o_index.
//   Instantiated once, on i_led.
//  Top holds led_q/valid_q, FSM, position/revolution counters, error capture.
// TESTING
//  Reset, then i_led=0001 held -> cycle 2: o_locked=1, o_pos=0, o_error=0.
//  Locked at 0001; 8 valid pulses, shifter-correct stepping -> o_pos back to 0; o_rev_count=2; no error.
//  Locked at 0010; i_led jumps to 1000 with no valid -> o_error=1, code 10; then held until i_clear.
//  Locked at 0100; valid pulse, LED unchanged -> code 11; then i_led=0110 -> state stays frozen.
//   Then i_clear -> UNLOCK; i_led=0001 -> relock, o_rev_count=0.
//  i_led=0000 after reset -> stays UNLOCK, no error. Locked, i_led=0011 -> code 01.
//   i_reset mid-ERROR -> all outputs at reset values next cycle.
//  BIDIR_EN: locked at 0001, valid, i_led=1000 -> o_pos=3, o_dir=0, o_rev_count=1.
//   Without BIDIR_EN: same stimulus -> code 10.

Source files
------------

// File: rtl/led_ring_pkg.sv
// Shared types for the LED ring monitor: FSM states, error codes and ring rotation helpers.
package led_ring_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_UNEXP  = 2'b10;
    localparam logic [1:0] ERR_MISS   = 2'b11;

    // Widest ring the rotation helpers support; callers truncate to their own width.
    localparam int MAX_LEDS = 32;

    function automatic logic [MAX_LEDS-1:0] rotl(input logic [MAX_LEDS-1:0] v,
                                                 input int unsigned n);
        logic [MAX_LEDS-1:0] mask;
        mask = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

    function automatic logic [MAX_LEDS-1:0] rotr(input logic [MAX_LEDS-1:0] v,
                                                 input int unsigned n);
        logic [MAX_LEDS-1:0] mask;
        mask = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n);
        return ((v >> 1) | (v << (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/led_ring_onehot_encoder.sv
// Combinational one-hot detector and index encoder for the observed LED vector.
module onehot_encoder #(
    parameter int NB_VEC = 4,
    parameter int NB_IDX = 2
) (
    input  logic [NB_VEC-1:0] i_vec,
    output logic              o_onehot,
    output logic [NB_IDX-1:0] o_index
);

    assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - NB_VEC'(1))) == '0);

    // Index is only meaningful when o_onehot is set.
    always_comb begin
        // NOTE: default assignment first so no path leaves o_index unassigned (no latch).
        o_index = '0;
        for (int i = 0; i < NB_VEC; i++) begin
            if (i_vec[i]) o_index = NB_IDX'(i);
        end
    end

endmodule

// File: rtl/led_ring_monitor.sv
// Protocol observer for the rotating one-hot LED shifter: tracks position, revolutions, sticky errors.
// Define LED_MON_BIDIR_EN to accept right-rotation steps as legal (o_dir then reports direction).
module led_ring_monitor
    import led_ring_pkg::*;
#(
    parameter int NB_LEDS = 4,
    parameter int NB_POS  = 2,
    parameter int NB_REV  = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_LEDS-1:0] i_led,
    input  logic               i_valid,
    input  logic               i_clear,
    output logic [NB_POS-1:0]  o_pos,
    output logic [NB_REV-1:0]  o_rev_count,
    output logic               o_locked,
    output logic               o_error,
    output logic [1:0]         o_err_code,
    output logic               o_dir
);

    localparam logic [NB_POS-1:0] POS_LAST = NB_POS'(NB_LEDS - 1);

    state_t             state_q;
    logic [NB_LEDS-1:0] led_q;
    logic               valid_q;
    logic [NB_POS-1:0]  pos_q, pos_fwd_d;
    logic [NB_REV-1:0]  rev_q, rev_fwd_d;
    logic               locked_q, error_q, dir_q;
    logic [1:0]         code_q;

    logic               led_onehot;
    logic [NB_POS-1:0]  led_index;
    logic [NB_LEDS-1:0] led_rotl;

    onehot_encoder #(.NB_VEC(NB_LEDS), .NB_IDX(NB_POS)) u_onehot_encoder (
        .i_vec    (i_led),
        .o_onehot (led_onehot),
        .o_index  (led_index)
    );

    assign led_rotl = NB_LEDS'(rotl(MAX_LEDS'(led_q), NB_LEDS));

    always_comb begin
        pos_fwd_d = pos_q + NB_POS'(1);
        rev_fwd_d = rev_q;
        if (pos_q == POS_LAST) begin
            pos_fwd_d = '0;
            rev_fwd_d = rev_q + NB_REV'(1);
        end
    end

`ifdef LED_MON_BIDIR_EN
    logic [NB_LEDS-1:0] led_rotr;
    logic [NB_POS-1:0]  pos_bwd_d;
    logic [NB_REV-1:0]  rev_bwd_d;

    assign led_rotr = NB_LEDS'(rotr(MAX_LEDS'(led_q), NB_LEDS));

    always_comb begin
        pos_bwd_d = pos_q - NB_POS'(1);
        rev_bwd_d = rev_q;
        if (pos_q == '0) begin
            pos_bwd_d = POS_LAST;
            rev_bwd_d = rev_q + NB_REV'(1);
        end
    end
`endif

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
        if (i_reset) begin
            state_q  <= ST_UNLOCK;
            led_q    <= '0;
            valid_q  <= 1'b0;
            pos_q    <= '0;
            rev_q    <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= ERR_NONE;
            dir_q    <= 1'b1;
        end else begin
            led_q   <= i_led;
            valid_q <= i_valid;
            if (i_clear) begin
                state_q  <= ST_UNLOCK;
                pos_q    <= '0;
                rev_q    <= '0;
                locked_q <= 1'b0;
                error_q  <= 1'b0;
                code_q   <= ERR_NONE;
            end else begin
                case (state_q)
                    ST_UNLOCK: begin
                        if (led_onehot) begin
                            state_q  <= ST_LOCKED;
                            pos_q    <= led_index;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // Left rotation is tested first, so a 2-LED ring always counts as a left step.
                        if (!led_onehot) begin
                            state_q  <= ST_ERROR;
                            locked_q <= 1'b0;
                            error_q  <= 1'b1;
                            code_q   <= ERR_ONEHOT;
                        end else if (valid_q && i_led == led_rotl) begin
                            pos_q <= pos_fwd_d;
                            rev_q <= rev_fwd_d;
                            dir_q <= 1'b1;
`ifdef LED_MON_BIDIR_EN
                        end else if (valid_q && i_led == led_rotr) begin
                            pos_q <= pos_bwd_d;
                            rev_q <= rev_bwd_d;
                            dir_q <= 1'b0;
`endif
                        end else if (valid_q && i_led == led_q) begin
                            state_q  <= ST_ERROR;
                            locked_q <= 1'b0;
                            error_q  <= 1'b1;
                            code_q   <= ERR_MISS;
                        end else if (i_led != led_q) begin
                            state_q  <= ST_ERROR;
                            locked_q <= 1'b0;
                            error_q  <= 1'b1;
                            code_q   <= ERR_UNEXP;
                        end
                    end
                    ST_ERROR: begin
                    end
                    default: state_q <= ST_UNLOCK;
                endcase
            end
        end
    end

    assign o_pos       = pos_q;
    assign o_rev_count = rev_q;
    assign o_locked    = locked_q;
    assign o_error     = error_q;
    assign o_err_code  = code_q;
    assign o_dir       = dir_q;

endmodule
